// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//   Multi-ported data memory for the AAP execute stage: four combinational
//   read ports and four clocked write ports over one DEPTH x DATA_WIDTH array.
//
// Ports
//   clock                         system clock, writes commit on rising edge
//   reset                         asynchronous active-high reset, clears array
//   data_rd1..data_rd4            read addresses
//   data_rd1_out..data_rd4_out    read data (combinational, 0 while in reset)
//   data_wr1..data_wr4            write addresses
//   data_wr1_data..data_wr4_data  write data
//   data_wr1_enable..4_enable     write enables
//
// Write collisions to one address resolve to the highest-numbered port.
// Addresses >= DEPTH read as 0 and writes to them are dropped.
//
// Optional feature macro: DATA_MEMORY_WRITE_BYPASS_EN
//   When defined, a read whose address matches an enabled write port returns
//   that port's write data in the same cycle (wr4 has highest priority).
//   When undefined, reads return the array contents (old data until the edge).
// -----------------------------------------------------------------------------
module data_memory #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] data_rd1,
  input  logic [ADDR_WIDTH-1:0] data_rd2,
  input  logic [ADDR_WIDTH-1:0] data_rd3,
  input  logic [ADDR_WIDTH-1:0] data_rd4,
  input  logic [ADDR_WIDTH-1:0] data_wr1,
  input  logic [ADDR_WIDTH-1:0] data_wr2,
  input  logic [ADDR_WIDTH-1:0] data_wr3,
  input  logic [ADDR_WIDTH-1:0] data_wr4,
  input  logic [DATA_WIDTH-1:0] data_wr1_data,
  input  logic [DATA_WIDTH-1:0] data_wr2_data,
  input  logic [DATA_WIDTH-1:0] data_wr3_data,
  input  logic [DATA_WIDTH-1:0] data_wr4_data,
  input  logic                  data_wr1_enable,
  input  logic                  data_wr2_enable,
  input  logic                  data_wr3_enable,
  input  logic                  data_wr4_enable,
  output logic [DATA_WIDTH-1:0] data_rd1_out,
  output logic [DATA_WIDTH-1:0] data_rd2_out,
  output logic [DATA_WIDTH-1:0] data_rd3_out,
  output logic [DATA_WIDTH-1:0] data_rd4_out
);

  localparam int NPORTS = 4;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Port bundles as arrays; index 0 is port 1, index 3 is port 4.
  logic [ADDR_WIDTH-1:0] rd_addr_s [NPORTS];
  logic [DATA_WIDTH-1:0] rd_data_s [NPORTS];
  logic [ADDR_WIDTH-1:0] wr_addr_s [NPORTS];
  logic [DATA_WIDTH-1:0] wr_data_s [NPORTS];
  logic                  wr_en_s   [NPORTS];

  assign rd_addr_s[0] = data_rd1;
  assign rd_addr_s[1] = data_rd2;
  assign rd_addr_s[2] = data_rd3;
  assign rd_addr_s[3] = data_rd4;

  assign wr_addr_s[0] = data_wr1;
  assign wr_addr_s[1] = data_wr2;
  assign wr_addr_s[2] = data_wr3;
  assign wr_addr_s[3] = data_wr4;

  assign wr_data_s[0] = data_wr1_data;
  assign wr_data_s[1] = data_wr2_data;
  assign wr_data_s[2] = data_wr3_data;
  assign wr_data_s[3] = data_wr4_data;

  assign wr_en_s[0] = data_wr1_enable;
  assign wr_en_s[1] = data_wr2_enable;
  assign wr_en_s[2] = data_wr3_enable;
  assign wr_en_s[3] = data_wr4_enable;

  assign data_rd1_out = rd_data_s[0];
  assign data_rd2_out = rd_data_s[1];
  assign data_rd3_out = rd_data_s[2];
  assign data_rd4_out = rd_data_s[3];

  // One extra bit so the compare never degenerates when DEPTH == 2**ADDR_WIDTH.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] ext;
    ext = {1'b0, addr};
    return (ext < (ADDR_WIDTH+1)'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[IDX_W-1:0];
  endfunction

  // Array update: later loop iterations override earlier ones, so wr4 wins a collision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (wr_en_s[p] && in_range(wr_addr_s[p])) begin
          mem_q[to_idx(wr_addr_s[p])] <= wr_data_s[p];
        end
      end
    end
  end

  // Combinational read path, optionally forwarding same-cycle write data.
  always_comb begin
    for (int r = 0; r < NPORTS; r++) begin
      rd_data_s[r] = '0;
      if (reset) begin
        rd_data_s[r] = '0;
      end else if (in_range(rd_addr_s[r])) begin
        rd_data_s[r] = mem_q[to_idx(rd_addr_s[r])];
`ifdef DATA_MEMORY_WRITE_BYPASS_EN
        // Ascending scan so the highest-numbered matching port is forwarded.
        for (int w = 0; w < NPORTS; w++) begin
          if (wr_en_s[w] && (wr_addr_s[w] == rd_addr_s[r])) begin
            rd_data_s[r] = wr_data_s[w];
          end else begin
            rd_data_s[r] = rd_data_s[r];
          end
        end
`endif
      end else begin
        rd_data_s[r] = '0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clock;
  logic          reset;
  logic [AW-1:0] rd_addr [4];
  logic [AW-1:0] wr_addr [4];
  logic [DW-1:0] wr_data [4];
  logic          wr_en   [4];
  logic [DW-1:0] rd_out  [4];

  data_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(512)) dut (
    .clock           (clock),
    .reset           (reset),
    .data_rd1        (rd_addr[0]),
    .data_rd2        (rd_addr[1]),
    .data_rd3        (rd_addr[2]),
    .data_rd4        (rd_addr[3]),
    .data_wr1        (wr_addr[0]),
    .data_wr2        (wr_addr[1]),
    .data_wr3        (wr_addr[2]),
    .data_wr4        (wr_addr[3]),
    .data_wr1_data   (wr_data[0]),
    .data_wr2_data   (wr_data[1]),
    .data_wr3_data   (wr_data[2]),
    .data_wr4_data   (wr_data[3]),
    .data_wr1_enable (wr_en[0]),
    .data_wr2_enable (wr_en[1]),
    .data_wr3_enable (wr_en[2]),
    .data_wr4_enable (wr_en[3]),
    .data_rd1_out    (rd_out[0]),
    .data_rd2_out    (rd_out[1]),
    .data_rd3_out    (rd_out[2]),
    .data_rd4_out    (rd_out[3])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] value;
  } exp_t;

  exp_t scb_q[$];
  event sample_ev;
  int   tests_run = 0;
  int   tests_failed = 0;

  // Monitor: whenever outputs are presented for sampling, drain and compare.
  initial begin
    forever begin
      @(sample_ev);
      while (scb_q.size() > 0) begin
        exp_t e;
        e = scb_q.pop_front();
        tests_run++;
        if (rd_out[e.port] !== e.value) begin
          tests_failed++;
          $display("FAIL %s rd%0d: got %h expected %h", e.name, e.port + 1, rd_out[e.port], e.value);
        end
      end
    end
  end

  task automatic expect_rd(input string name, input int port, input logic [31:0] value);
    exp_t e;
    e.name = name;
    e.port = port;
    e.value = value;
    scb_q.push_back(e);
  endtask

  task automatic expect_all(input string name, input logic [31:0] value);
    for (int p = 0; p < 4; p++) expect_rd(name, p, value);
  endtask

  // Let combinational outputs settle, then hand them to the monitor.
  task automatic present();
    #1;
    -> sample_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic en);
    wr_addr[p] = a;
    wr_data[p] = d;
    wr_en[p]   = en;
  endtask

  task automatic clear_wr();
    for (int p = 0; p < 4; p++) set_wr(p, 9'd0, 32'd0, 1'b0);
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    rd_addr[0] = a0;
    rd_addr[1] = a1;
    rd_addr[2] = a2;
    rd_addr[3] = a3;
  endtask

  initial begin
    reset = 1'b1;
    clear_wr();
    set_rd(9'd0, 9'd0, 9'd0, 9'd0);

    // Reset state
    #2;
    expect_all("reset_state", 32'd0);
    present();
    #3;               // t=7, between edges
    reset = 1'b0;

    // Preload mem[5], then async reset between edges
    set_wr(0, 9'd5, 32'h0000_1234, 1'b1);
    tick();
    clear_wr();
    set_rd(9'd5, 9'd5, 9'd5, 9'd5);
    expect_all("preload5", 32'h0000_1234);
    present();
    #1;
    reset = 1'b1;
    expect_all("async_reset_out", 32'd0);
    present();
    // A write attempted while reset is held must be ignored
    set_wr(0, 9'd5, 32'hFFFF_FFFF, 1'b1);
    tick();
    #2;
    reset = 1'b0;
    clear_wr();
    expect_all("after_reset5", 32'd0);
    present();

    // Basic write/read, all four ports aliasing address 3
    set_rd(9'd3, 9'd3, 9'd3, 9'd3);
    set_wr(0, 9'd3, 32'hDEAD_BEEF, 1'b1);
`ifdef DATA_MEMORY_WRITE_BYPASS_EN
    expect_all("basic_before_edge", 32'hDEAD_BEEF);
`else
    expect_all("basic_before_edge", 32'd0);
`endif
    present();
    tick();
    clear_wr();
    expect_all("basic_after_edge", 32'hDEAD_BEEF);
    present();

    // Parallel writes in one edge
    set_wr(0, 9'd0,   32'd1, 1'b1);
    set_wr(1, 9'd1,   32'd2, 1'b1);
    set_wr(2, 9'd2,   32'd3, 1'b1);
    set_wr(3, 9'd511, 32'd4, 1'b1);
    tick();
    clear_wr();
    set_rd(9'd0, 9'd1, 9'd2, 9'd511);
    expect_rd("parallel", 0, 32'd1);
    expect_rd("parallel", 1, 32'd2);
    expect_rd("parallel", 2, 32'd3);
    expect_rd("parallel", 3, 32'd4);
    present();

    // Collision wr1/wr2/wr4 on 7; wr3 independently to 8
    set_wr(0, 9'd7, 32'd11, 1'b1);
    set_wr(1, 9'd7, 32'd22, 1'b1);
    set_wr(2, 9'd8, 32'd88, 1'b1);
    set_wr(3, 9'd7, 32'd44, 1'b1);
    tick();
    clear_wr();
    set_rd(9'd7, 9'd8, 9'd511, 9'd3);
    expect_rd("collision_w4", 0, 32'd44);
    expect_rd("collision_noncolliding", 1, 32'd88);
    expect_rd("collision_untouched", 2, 32'd4);
    expect_rd("collision_untouched", 3, 32'hDEAD_BEEF);
    present();

    // Collision wr1/wr3 on 7, wr4 disabled but aimed at 7
    set_wr(0, 9'd7, 32'd11, 1'b1);
    set_wr(2, 9'd7, 32'd33, 1'b1);
    set_wr(3, 9'd7, 32'd99, 1'b0);
    tick();
    clear_wr();
    expect_rd("collision_w3", 0, 32'd33);
    present();

    // Disabled writes on every port
    for (int p = 0; p < 4; p++) set_wr(p, 9'd9, 32'hFFFF_FFFF, 1'b0);
    tick();
    clear_wr();
    set_rd(9'd9, 9'd9, 9'd9, 9'd9);
    expect_all("disabled_write", 32'd0);
    present();

    // Read during write on port 2 / address 20
    set_rd(9'd9, 9'd20, 9'd9, 9'd9);
    set_wr(2, 9'd20, 32'hA5A5_A5A5, 1'b1);
`ifdef DATA_MEMORY_WRITE_BYPASS_EN
    expect_rd("rdw_before_edge", 1, 32'hA5A5_A5A5);
`else
    expect_rd("rdw_before_edge", 1, 32'd0);
`endif
    expect_rd("rdw_other_port", 0, 32'd0);
    present();
    tick();
    clear_wr();
    expect_rd("rdw_after_edge", 1, 32'hA5A5_A5A5);
    present();

    #5;
    if (scb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", scb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
